// File: rtl/soc_ram_arbiter.sv
// Two-master (CPU/DMA) arbiter and bridge onto the single-port data RAM.
// DMA has priority; the CPU is force-granted after MAX_WAIT contested losses.
module soc_ram_arbiter #(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256,
    parameter int MAX_WAIT = 4
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                cpu_req,
    input  logic [ADDR_MSB:0]   cpu_addr,
    input  logic [1:0]          cpu_we,
    input  logic [15:0]         cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [15:0]         cpu_rdata,
    output logic                cpu_rerr,
    input  logic                dma_req,
    input  logic [ADDR_MSB:0]   dma_addr,
    input  logic [1:0]          dma_we,
    input  logic [15:0]         dma_wdata,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [15:0]         dma_rdata,
    output logic                dma_rerr,
    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [15:0]         ram_din,
    output logic [1:0]          ram_wen,
    input  logic [15:0]         ram_dout
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam int         WORDS    = MEM_SIZE / 2;
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt;
    owner_t            rd_owner;
    logic              rd_oor;

    logic              cpu_win;
    logic              dma_win;
    logic              win_any;
    logic [ADDR_MSB:0] win_addr;
    logic [1:0]        win_we;
    logic [15:0]       win_wdata;
    logic              win_in_range;

    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (!puc_rst) begin
            if (cpu_req && dma_req) begin
                cpu_win = (wait_cnt == WAIT_LIM);
                dma_win = !cpu_win;
            end else begin
                cpu_win = cpu_req;
                dma_win = dma_req;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_we    = 2'b00;
        win_wdata = 16'h0000;
        if (cpu_win) begin
            win_addr  = cpu_addr;
            win_we    = cpu_we;
            win_wdata = cpu_wdata;
        end else if (dma_win) begin
            win_addr  = dma_addr;
            win_we    = dma_we;
            win_wdata = dma_wdata;
        end
    end

    assign win_any      = cpu_win || dma_win;
    assign win_in_range = ({{(31-ADDR_MSB){1'b0}}, win_addr} < 32'(WORDS));

    assign cpu_gnt  = cpu_win;
    assign dma_gnt  = dma_win;
    // Out-of-range accesses are granted so the master never stalls, but the RAM stays disabled.
    assign ram_cen  = !(win_any && win_in_range);
    assign ram_wen  = win_any ? ~win_we : 2'b11;
    assign ram_addr = win_addr;
    assign ram_din  = win_wdata;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wait_cnt <= 4'd0;
            rd_owner <= OWN_NONE;
            rd_oor   <= 1'b0;
        end else begin
            if (!cpu_req || cpu_win) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt < WAIT_LIM) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (win_any && (win_we == 2'b00)) begin
                rd_owner <= cpu_win ? OWN_CPU : OWN_DMA;
                rd_oor   <= !win_in_range;
            end else begin
                rd_owner <= OWN_NONE;
                rd_oor   <= 1'b0;
            end
        end
    end

    assign cpu_rvalid = (rd_owner == OWN_CPU) && !puc_rst;
    assign dma_rvalid = (rd_owner == OWN_DMA) && !puc_rst;
    assign cpu_rerr   = cpu_rvalid && rd_oor;
    assign dma_rerr   = dma_rvalid && rd_oor;
    assign cpu_rdata  = (cpu_rvalid && !rd_oor) ? ram_dout : 16'h0000;
    assign dma_rdata  = (dma_rvalid && !rd_oor) ? ram_dout : 16'h0000;

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Directed bench for soc_ram_arbiter with a behavioural RAM; read responses are
// checked by a monitor against a queue filled when each access is issued.
module tb_soc_ram_arbiter;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        cpu_req, dma_req;
    logic [6:0]  cpu_addr, dma_addr;
    logic [1:0]  cpu_we, dma_we;
    logic [15:0] cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_rerr;
    logic        dma_gnt, dma_rvalid, dma_rerr;
    logic [15:0] cpu_rdata, dma_rdata;
    logic [6:0]  ram_addr;
    logic        ram_cen;
    logic [15:0] ram_din;
    logic [1:0]  ram_wen;
    logic [15:0] ram_dout;

    typedef struct {
        logic        to_cpu;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    rsp_t        rsp_q[$];
    rsp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic        last_cpu_rvalid;
    logic [15:0] mem [0:63];

    always #5 mclk = ~mclk;

    soc_ram_arbiter #(.ADDR_MSB(6), .MEM_SIZE(128), .MAX_WAIT(4)) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_rerr(cpu_rerr),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_rerr(dma_rerr),
        .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_din(ram_din), .ram_wen(ram_wen),
        .ram_dout(ram_dout)
    );

    // Stand-in for soc_ram_sp: 64 words, addresses alias on the low 6 bits.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
    end

    always @(posedge mclk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) mem[ram_addr[5:0]][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) mem[ram_addr[5:0]][15:8] <= ram_din[15:8];
            ram_dout <= mem[ram_addr[5:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge mclk) begin
        if (cpu_rvalid || dma_rvalid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
            end else begin
                mon_e = rsp_q.pop_front();
                chk("rsp_owner", {30'd0, cpu_rvalid, dma_rvalid}, mon_e.to_cpu ? 32'd2 : 32'd1);
                chk("rsp_rdata", mon_e.to_cpu ? cpu_rdata : dma_rdata, {16'd0, mon_e.data});
                chk("rsp_rerr", mon_e.to_cpu ? cpu_rerr : dma_rerr, {31'd0, mon_e.err});
                chk("rsp_other_rdata", mon_e.to_cpu ? dma_rdata : cpu_rdata, 32'd0);
            end
        end
    end

    // Called at posedge+1: drives one cycle of requests, checks grant and RAM-side signals.
    task automatic cyc(input string nm,
                       input logic cr, input logic [1:0] cw, input logic [6:0] ca, input logic [15:0] cd,
                       input logic dr, input logic [1:0] dw, input logic [6:0] da, input logic [15:0] dd,
                       input logic ecg, input logic edg, input logic [15:0] erd, input logic rsp);
        logic [1:0]  ew;
        logic [6:0]  ea;
        logic [15:0] ed;
        logic        any;
        logic        ein;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        ew = 2'b00; ea = 7'd0; ed = 16'h0000;
        if (ecg) begin ew = cw; ea = ca; ed = cd; end
        else if (edg) begin ew = dw; ea = da; ed = dd; end
        any = ecg | edg;
        ein = (ea < 7'd64);
        @(negedge mclk);
        last_cpu_rvalid = cpu_rvalid;
        chk({nm, "_cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, ecg});
        chk({nm, "_dma_gnt"}, {31'd0, dma_gnt}, {31'd0, edg});
        chk({nm, "_ram_cen"}, {31'd0, ram_cen}, {31'd0, !(any && ein)});
        chk({nm, "_ram_wen"}, {30'd0, ram_wen}, any ? {30'd0, ~ew} : 32'd3);
        chk({nm, "_ram_addr"}, {25'd0, ram_addr}, {25'd0, ea});
        chk({nm, "_ram_din"}, {16'd0, ram_din}, {16'd0, ed});
        if (any && ew == 2'b00 && rsp) rsp_q.push_back('{ecg, erd, !ein});
        @(posedge mclk);
        #1;
    endtask

    task automatic idle();
        cyc("idle", 0, 2'b00, 7'd0, 16'h0, 0, 2'b00, 7'd0, 16'h0, 0, 0, 16'h0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        puc_rst = 1'b1;
        cpu_req = 1'b1; cpu_addr = 7'd0; cpu_we = 2'b00; cpu_wdata = 16'h0;
        dma_req = 1'b1; dma_addr = 7'd0; dma_we = 2'b00; dma_wdata = 16'h0;
        last_cpu_rvalid = 1'b0;
        repeat (2) @(negedge mclk);
        chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rst_ram_cen", {31'd0, ram_cen}, 32'd1);
        chk("rst_ram_wen", {30'd0, ram_wen}, 32'd3);
        chk("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        cyc("rst_rel", 1, 2'b00, 7'd0, 16'h0, 1, 2'b00, 7'd0, 16'h0, 0, 1, 16'h0000, 1);
        idle();

        cyc("cpu_wr5", 1, 2'b11, 7'd5, 16'hA55A, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'h0, 1);
        cyc("cpu_rd5", 1, 2'b00, 7'd5, 16'h0, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'hA55A, 1);
        idle();

        cyc("wr3_full", 1, 2'b11, 7'd3, 16'h1234, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'h0, 1);
        cyc("wr3_lo", 1, 2'b01, 7'd3, 16'hFFEE, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'h0, 1);
        cyc("rd3_a", 1, 2'b00, 7'd3, 16'h0, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'h12EE, 1);
        cyc("wr3_hi", 0, 2'b00, 7'd0, 16'h0, 1, 2'b10, 7'd3, 16'h77AB, 0, 1, 16'h0, 1);
        cyc("rd3_b", 0, 2'b00, 7'd0, 16'h0, 1, 2'b00, 7'd3, 16'h0, 0, 1, 16'h77EE, 1);
        idle();

        for (int i = 0; i < 10; i++)
            cyc("cont", 1, 2'b00, 7'd5, 16'h0, 1, 2'b00, 7'd5, 16'h0,
                (i == 4 || i == 9), !(i == 4 || i == 9), 16'hA55A, 1);
        idle();

        cyc("oor_rd", 0, 2'b00, 7'd0, 16'h0, 1, 2'b00, 7'd127, 16'h0, 0, 1, 16'h0000, 1);
        cyc("oor_wr", 0, 2'b00, 7'd0, 16'h0, 1, 2'b11, 7'd127, 16'hBEEF, 0, 1, 16'h0, 1);
        cyc("alias_rd", 0, 2'b00, 7'd0, 16'h0, 1, 2'b00, 7'd63, 16'h0, 0, 1, 16'h0000, 1);
        idle();

        cyc("b2b_wr1", 1, 2'b11, 7'd1, 16'h0001, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'h0, 1);
        cyc("b2b_wr2", 1, 2'b11, 7'd2, 16'h0002, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'h0, 1);
        cyc("b2b_rd1", 1, 2'b00, 7'd1, 16'h0, 0, 2'b00, 7'd0, 16'h0, 1, 0, 16'h0001, 1);
        cyc("b2b_rd2", 0, 2'b00, 7'd0, 16'h0, 1, 2'b00, 7'd2, 16'h0, 0, 1, 16'h0002, 1);
        chk("b2b_overlap", {31'd0, last_cpu_rvalid}, 32'd1);
        idle();

        for (int i = 0; i < 3; i++)
            cyc("pre_rst", 1, 2'b00, 7'd5, 16'h0, 1, 2'b00, 7'd5, 16'h0, 0, 1, 16'hA55A, i < 2);
        puc_rst = 1'b1;
        @(negedge mclk);
        chk("midrst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'd0);
        chk("midrst_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        for (int i = 0; i < 5; i++)
            cyc("post_rst", 1, 2'b00, 7'd5, 16'h0, 1, 2'b00, 7'd5, 16'h0, (i == 4), (i != 4), 16'hA55A, 1);
        idle();
        idle();

        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_ram_arbiter.md
# soc_ram_arbiter

Two-master arbiter and protocol bridge sitting directly upstream of the single-port data RAM (`soc_ram_sp`). It merges a CPU port and a DMA port onto the RAM's chip-enable/byte-write-enable interface and maps active-high byte enables to the RAM's active-low `ram_wen`. It returns one-cycle-latency read responses to the winning master. Arbitration is DMA-priority with a bounded-wait starvation guard for the CPU.

## Interface
Parameters:
- `ADDR_MSB`, 6: MSB of the word address. Must match the RAM instance.
- `MEM_SIZE`, 256: RAM size in bytes. Valid word addresses are 0 .. MEM_SIZE/2-1.
- `MAX_WAIT`, 4: maximum consecutive contested cycles the CPU can lose before it is forced a grant. Range 1..15.

Ports (name, direction, width, meaning):
- `mclk` in 1: single clock. Also drives `ram_clk` of the RAM.
- `puc_rst` in 1: reset, asynchronous, active-high.
- `cpu_req` in 1: CPU access request. Held, with its qualifiers stable, until `cpu_gnt`.
- `cpu_addr` in ADDR_MSB+1: CPU word address.
- `cpu_we` in 2: CPU byte write enables, active-high. [1] = high byte, [0] = low byte. 00 = read.
- `cpu_wdata` in 16: CPU write data.
- `cpu_gnt` out 1: CPU request accepted this cycle.
- `cpu_rvalid` out 1: CPU read response valid.
- `cpu_rdata` out 16: CPU read data.
- `cpu_rerr` out 1: CPU response is for an out-of-range address.
- `dma_req`, `dma_addr`, `dma_we`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`, `dma_rerr`: same widths and meanings as the CPU port, for the DMA master.
- `ram_addr` out ADDR_MSB+1: RAM address.
- `ram_cen` out 1: RAM chip enable, active-low.
- `ram_din` out 16: RAM write data.
- `ram_wen` out 2: RAM byte write enable, active-low.
- `ram_dout` in 16: RAM read data. Reflects the last enabled address, one cycle after access.

## Operation
- Grant is combinational from requests plus registered state. At most one of `cpu_gnt`/`dma_gnt` is high in a cycle.
- Only DMA requesting: DMA granted. Only CPU requesting: CPU granted.
- Both requesting:
  - DMA wins while `wait_cnt < MAX_WAIT`.
  - CPU wins when `wait_cnt == MAX_WAIT`.
- `wait_cnt` (4-bit):
  - Increments when the CPU requests and is not granted.
  - Clears to 0 on a CPU grant or when `cpu_req` is low.
  - Saturates at MAX_WAIT.
- Granted access drives `ram_addr`/`ram_din` from the winner and `ram_wen = ~winner_we`. Examples: we=11 gives wen=00, we=01 gives wen=10 (low-byte write), we=00 gives wen=11 (read).
- `ram_cen` = 0 only when a grant is issued and the address is below MEM_SIZE/2. Out-of-range accesses are still granted (no deadlock) but never reach the RAM.
- No grant: `ram_cen`=1, `ram_wen`=11, `ram_addr`/`ram_din` = 0.
- Read response pipeline:
  - A granted read (we=00) sets registered `rd_owner` (NONE/CPU/DMA) and `rd_oor` for the next cycle.
  - In that next cycle, the owner's `*_rvalid`=1.
  - `*_rdata` = `ram_dout` when in range. When `rd_oor`, `*_rdata` = 16'h0000 and `*_rerr`=1.
- Writes produce no response. `*_gnt` is their completion; the RAM updates on the same `mclk` edge.
- Non-owner `*_rvalid`/`*_rerr` = 0 and `*_rdata` = 0.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - `wait_cnt`=0, `rd_owner`=NONE, `rd_oor`=0.
  - While `puc_rst`=1: all grants 0, `ram_cen`=1, `ram_wen`=11, all rvalid/rerr 0, all rdata 0.
- Latency: grant in request cycle N (zero wait if uncontested). RAM writes at the end of N. Read data valid in cycle N+1 only (single-cycle pulse).
- Back-to-back: one access per cycle sustained. The response for N and a new grant in N+1 coexist.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset mid-operation: pending response in N+1 is discarded (rvalid forced 0), and `wait_cnt` clears.
- Request dropped without grant is legal. No state is retained except that `wait_cnt` clears.

## Test plan
- Reset: assert `puc_rst` with both reqs high. Expect gnts=0, `ram_cen`=1, `ram_wen`=11, rvalid=0. Release; DMA is granted the first cycle.
- CPU write `cpu_addr`=5, we=11, wdata=16'hA55A, then read addr 5. Expect `ram_wen`=00 on the write, then rvalid one cycle after the read grant with rdata=16'hA55A and `dma_rvalid`=0.
- Byte write: write 16'h1234 to addr 3, then we=01 with wdata 16'hFFEE. Expect `ram_wen`=10, readback 16'h12EE. Then we=10 with wdata 16'h77xx; readback 16'h77EE.
- Contention, MAX_WAIT=4, both reqs held continuously: expect grant sequence DMA,DMA,DMA,DMA,CPU,DMA,DMA,DMA,DMA,CPU.
- Out-of-range: DMA reads addr 127 with MEM_SIZE=128. Expect `dma_gnt`=1 and `ram_cen`=1, then next cycle `dma_rvalid`=1, `dma_rerr`=1, `dma_rdata`=0. RAM contents unchanged.
- Back-to-back: CPU reads addr 1 then DMA reads addr 2 in consecutive cycles, with mem[1]=16'h0001 and mem[2]=16'h0002. Expect `cpu_rvalid` with 16'h0001 in the same cycle as `dma_gnt`, then `dma_rvalid` with 16'h0002.
